// File: rtl/fetch_buffer_if.sv
// Fetch/decode side bundle of the instruction fetch buffer.
// Master drives enqueue/pop/flush; slave (the buffer) returns entries and status.
interface fetch_buffer_if #(
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 3
);
   logic               enq_valid;
   logic [PC_W-1:0]    enq_pc;
   logic [INSTR_W-1:0] enq_instr;
   logic               enq_ready;
   logic [1:0]         deq_num;
   logic               flush;
   logic               deq0_valid;
   logic [PC_W-1:0]    deq0_pc;
   logic [INSTR_W-1:0] deq0_instr;
   logic               deq1_valid;
   logic [PC_W-1:0]    deq1_pc;
   logic [INSTR_W-1:0] deq1_instr;
   logic [CNT_W-1:0]   count;
   logic               empty;
   logic               full;
   logic               underflow_err;

   modport master (
      output enq_valid, enq_pc, enq_instr, deq_num, flush,
      input  enq_ready, deq0_valid, deq0_pc, deq0_instr,
             deq1_valid, deq1_pc, deq1_instr, count, empty, full, underflow_err
   );

   modport slave (
      input  enq_valid, enq_pc, enq_instr, deq_num, flush,
      output enq_ready, deq0_valid, deq0_pc, deq0_instr,
             deq1_valid, deq1_pc, deq1_instr, count, empty, full, underflow_err
   );
endinterface

// File: rtl/fetch_buffer.sv
// Dual-read instruction FIFO between fetch and decode: one push per cycle,
// up to two pops per cycle, flush on redirect, sticky underflow flag.
module fetch_buffer #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 64,
   parameter int INSTR_W = 32
) (
   input logic           clk,
   input logic           rst_n,
   fetch_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]    r_pc_mem    [DEPTH];
   logic [INSTR_W-1:0] r_instr_mem [DEPTH];

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_underflow;

   logic [PTR_W-1:0] w_head_next;
   logic [PTR_W-1:0] w_tail_next;
   logic [PTR_W-1:0] w_head1;
   logic [CNT_W-1:0] w_count_next;
   logic [CNT_W-1:0] w_deq_req;
   logic [CNT_W-1:0] w_pop_n;
   logic             w_underflow_next;
   logic             w_full;
   logic             w_fire;
   logic             w_deq0_valid;
   logic             w_deq1_valid;

   // Ready depends on registered occupancy only; a same-cycle pop gives no credit.
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_fire  = bus.enq_valid && !w_full;

   assign w_deq_req = (bus.deq_num == 2'd3) ? CNT_W'(2) : CNT_W'(bus.deq_num);
   assign w_pop_n   = (w_deq_req > r_count) ? r_count : w_deq_req;
   assign w_head1   = r_head + PTR_W'(1);

   always_comb begin
      w_head_next      = r_head;
      w_tail_next      = r_tail;
      w_count_next     = r_count;
      w_underflow_next = r_underflow;
      if (bus.flush) begin
         w_head_next  = '0;
         w_tail_next  = '0;
         w_count_next = '0;
      end else begin
         w_head_next  = r_head + PTR_W'(w_pop_n);
         w_count_next = r_count + CNT_W'(w_fire) - w_pop_n;
         if (w_fire) begin
            w_tail_next = r_tail + PTR_W'(1);
         end
         if ((bus.deq_num == 2'd3) || (CNT_W'(bus.deq_num) > r_count)) begin
            w_underflow_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_head      <= w_head_next;
         r_tail      <= w_tail_next;
         r_count     <= w_count_next;
         r_underflow <= w_underflow_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fire && !bus.flush) begin
         r_pc_mem[r_tail]    <= bus.enq_pc;
         r_instr_mem[r_tail] <= bus.enq_instr;
      end
   end

   assign w_deq0_valid = (r_count != '0);
   assign w_deq1_valid = (r_count >= CNT_W'(2));

   assign bus.enq_ready     = !w_full;
   assign bus.count         = r_count;
   assign bus.empty         = (r_count == '0);
   assign bus.full          = w_full;
   assign bus.underflow_err = r_underflow;

   // Data is forced to zero when its valid is low so nothing stale leaks out.
   assign bus.deq0_valid = w_deq0_valid;
   assign bus.deq0_pc    = w_deq0_valid ? r_pc_mem[r_head]    : '0;
   assign bus.deq0_instr = w_deq0_valid ? r_instr_mem[r_head] : '0;
   assign bus.deq1_valid = w_deq1_valid;
   assign bus.deq1_pc    = w_deq1_valid ? r_pc_mem[w_head1]    : '0;
   assign bus.deq1_instr = w_deq1_valid ? r_instr_mem[w_head1] : '0;
endmodule
